// File: rtl/ras_stack.sv
// Purpose : circular return-address stack feeding predicted return targets to fetch.
// Latency : updates on the rising edge; outputs decode registered state (zero read latency).
// Backpressure: none; stall freezes all state, overflow overwrites the oldest entry.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   stall           hold all state; push/pop ignored
//   flush           empty the stack (mispredict recovery); entries and counters kept
//   push, pop       stack operations from the execute-stage decoder
//   addr_in         return address (PC+4 of a linking jump) to push
//   addr_out        top of stack, 32'h0 when empty
//   empty, full     count == 0 / count == DEPTH
//   ovf_cnt         saturating count of pushes that overwrote an entry
//   udf_cnt         saturating count of pops ignored while empty
module ras_stack #(
  parameter int RAS_INDEX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] addr_in,
  output logic [31:0] addr_out,
  output logic        empty,
  output logic        full,
  output logic [15:0] ovf_cnt,
  output logic [15:0] udf_cnt
);

  localparam int DEPTH = 1 << RAS_INDEX;
  localparam logic [RAS_INDEX:0] FULL_COUNT = (RAS_INDEX + 1)'(DEPTH);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [31:0]          mem [DEPTH];
  logic [RAS_INDEX-1:0] top;
  logic [RAS_INDEX:0]   count;

  // Operation decode. A push+pop on an empty stack degrades to a plain push,
  // so the underflow counter only sees a lone pop against an empty stack.
  logic                 active;
  logic                 nonempty;
  logic                 op_replace;
  logic                 op_push;
  logic                 op_pop;
  logic                 op_udf;
  logic                 op_ovf;
  logic                 mem_we;
  logic [RAS_INDEX-1:0] top_inc;
  logic [RAS_INDEX-1:0] top_dec;
  logic [RAS_INDEX-1:0] wr_idx;

  always_comb begin
    active     = !rst && !flush && !stall;
    nonempty   = (count != '0);
    op_replace = push && pop && nonempty;
    op_push    = push && !op_replace;
    op_pop     = pop && !push && nonempty;
    op_udf     = pop && !push && !nonempty;
    op_ovf     = op_push && (count == FULL_COUNT);
    top_inc    = top + RAS_INDEX'(1);
    top_dec    = top - RAS_INDEX'(1);
    // Replace rewrites the current top in place; push writes the next slot,
    // which on a full stack is the oldest entry (pointer wraps onto it).
    wr_idx     = op_replace ? top : top_inc;
    mem_we     = active && (op_push || op_replace);
  end

  // Control state: pointer, occupancy and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      top     <= '0;
      count   <= '0;
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (flush) begin
      top   <= '0;
      count <= '0;
    end else if (!stall) begin
      if (op_push) begin
        top <= top_inc;
        if (!op_ovf) begin
          count <= count + (RAS_INDEX + 1)'(1);
        end else if (ovf_cnt != CNT_MAX) begin
          ovf_cnt <= ovf_cnt + 16'd1;
        end
      end else if (op_pop) begin
        top   <= top_dec;
        count <= count - (RAS_INDEX + 1)'(1);
      end else if (op_udf) begin
        if (udf_cnt != CNT_MAX) begin
          udf_cnt <= udf_cnt + 16'd1;
        end
      end
    end
  end

  // Storage has no reset; entries above the top are never observed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= addr_in;
    end
  end

  // Outputs depend only on registered state, never on push/pop/addr_in.
  always_comb begin
    empty    = (count == '0);
    full     = (count == FULL_COUNT);
    addr_out = empty ? 32'h0 : mem[top];
  end

endmodule

// File: tb/tb_ras_stack.sv
module tb_ras_stack;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        push;
  logic        pop;
  logic [31:0] addr_in;
  logic [31:0] addr_out;
  logic        empty;
  logic        full;
  logic [15:0] ovf_cnt;
  logic [15:0] udf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a bounded list of live return addresses, oldest first.
  logic [31:0] mq[$];
  logic [15:0] m_ovf;
  logic [15:0] m_udf;

  ras_stack #(.RAS_INDEX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .addr_in  (addr_in),
    .addr_out (addr_out),
    .empty    (empty),
    .full     (full),
    .ovf_cnt  (ovf_cnt),
    .udf_cnt  (udf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [65:0] exp_vec();
    logic [31:0] a;
    a = (mq.size() > 0) ? mq[mq.size()-1] : 32'h0;
    return {a, (mq.size() == 0), (mq.size() == 8), m_ovf, m_udf};
  endfunction

  function automatic logic [65:0] dut_vec();
    return {addr_out, empty, full, ovf_cnt, udf_cnt};
  endfunction

  // Apply one cycle of inputs and advance the model by the same rules.
  task automatic drive(input logic r, input logic f, input logic s,
                       input logic pu, input logic po, input logic [31:0] a);
    rst = r; flush = f; stall = s; push = pu; pop = po; addr_in = a;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 16'h0;
      m_udf = 16'h0;
    end else if (f) begin
      mq.delete();
    end else if (s) begin
      // frozen
    end else if (pu && po && mq.size() > 0) begin
      mq[mq.size()-1] = a;
    end else if (pu) begin
      if (mq.size() == 8) begin
        void'(mq.pop_front());
        if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      end
      mq.push_back(a);
    end else if (po) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else if (m_udf != 16'hFFFF) m_udf = m_udf + 16'd1;
    end
    #1;
    rst = 1'b0; flush = 1'b0; stall = 1'b0; push = 1'b0; pop = 1'b0;
    addr_in = 32'h0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 32'h0);
    n_tests++;
    if (dut_vec() !== {32'h0, 1'b1, 1'b0, 16'h0, 16'h0}) begin
      $display("FAIL reset_state: got %h expected %h", dut_vec(),
               {32'h0, 1'b1, 1'b0, 16'h0, 16'h0});
      n_fail++;
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_push [3];
    logic [31:0] exp_pop [3];
    exp_push = '{32'h100, 32'h104, 32'h108};
    exp_pop  = '{32'h104, 32'h100, 32'h0};
    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, exp_push[i]);
      n_tests++;
      if (addr_out !== exp_push[i] || empty !== 1'b0) begin
        $display("FAIL push_%0d: got addr %h empty %b expected addr %h empty 0",
                 i, addr_out, empty, exp_push[i]);
        n_fail++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 32'h0);
      n_tests++;
      if (addr_out !== exp_pop[i] || empty !== (i == 2)) begin
        $display("FAIL pop_%0d: got addr %h empty %b expected addr %h empty %b",
                 i, addr_out, empty, exp_pop[i], (i == 2));
        n_fail++;
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 1, 0, 32'h200 + 32'(4 * i));
      if (i == 6 || i == 7) begin
        n_tests++;
        if (full !== (i == 7) || ovf_cnt !== 16'h0) begin
          $display("FAIL ovf_full_%0d: got full %b ovf %h expected full %b ovf 0",
                   i, full, ovf_cnt, (i == 7));
          n_fail++;
        end
      end
    end
    n_tests++;
    if (ovf_cnt !== 16'd1 || addr_out !== 32'h220 || full !== 1'b1) begin
      $display("FAIL ovf_ninth: got ovf %h addr %h full %b expected 1 00000220 1",
               ovf_cnt, addr_out, full);
      n_fail++;
    end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (addr_out !== 32'h220 - 32'(4 * k)) begin
        $display("FAIL ovf_drain_%0d: got %h expected %h", k, addr_out,
                 32'h220 - 32'(4 * k));
        n_fail++;
      end
      drive(0, 0, 0, 0, 1, 32'h0);
    end
    n_tests++;
    if (empty !== 1'b1 || addr_out !== 32'h0) begin
      $display("FAIL ovf_empty: got empty %b addr %h expected 1 00000000", empty, addr_out);
      n_fail++;
    end
  endtask

  task automatic test_underflow();
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0);
    n_tests++;
    if (udf_cnt !== 16'd2 || addr_out !== 32'h0 || empty !== 1'b1) begin
      $display("FAIL udf_two: got udf %h addr %h empty %b expected 2 0 1",
               udf_cnt, addr_out, empty);
      n_fail++;
    end
    drive(0, 0, 0, 1, 1, 32'h300);
    n_tests++;
    if (addr_out !== 32'h300 || empty !== 1'b0 || udf_cnt !== 16'd2) begin
      $display("FAIL udf_pushpop: got addr %h empty %b udf %h expected 300 0 2",
               addr_out, empty, udf_cnt);
      n_fail++;
    end
    drive(0, 0, 0, 0, 1, 32'h0);
    n_tests++;
    if (empty !== 1'b1 || udf_cnt !== 16'd2) begin
      $display("FAIL udf_count_one: got empty %b udf %h expected 1 2", empty, udf_cnt);
      n_fail++;
    end
  endtask

  task automatic test_replace();
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h400);
    drive(0, 0, 0, 1, 1, 32'h500);
    n_tests++;
    if (addr_out !== 32'h500 || empty !== 1'b0) begin
      $display("FAIL replace_top: got addr %h empty %b expected 500 0", addr_out, empty);
      n_fail++;
    end
    drive(0, 0, 0, 0, 1, 32'h0);
    n_tests++;
    if (empty !== 1'b1 || addr_out !== 32'h0) begin
      $display("FAIL replace_count: got empty %b addr %h expected 1 0", empty, addr_out);
      n_fail++;
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h600);
    drive(0, 0, 1, 1, 0, 32'h700);
    drive(0, 0, 1, 1, 1, 32'h700);
    drive(0, 0, 1, 0, 1, 32'h0);
    n_tests++;
    if (addr_out !== 32'h600 || empty !== 1'b0 || udf_cnt !== 16'd1) begin
      $display("FAIL stall_hold: got addr %h empty %b udf %h expected 600 0 1",
               addr_out, empty, udf_cnt);
      n_fail++;
    end
    drive(0, 1, 0, 1, 0, 32'h800);
    n_tests++;
    if (dut_vec() !== {32'h0, 1'b1, 1'b0, 16'h0, 16'h1}) begin
      $display("FAIL flush_push: got %h expected %h", dut_vec(),
               {32'h0, 1'b1, 1'b0, 16'h0, 16'h1});
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic r, f, s, pu, po;
    int errs;
    errs = 0;
    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 7) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 40);
      drive(r, f, s, pu, po, $urandom);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        if (errs < 10)
          $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
        errs++;
        n_fail++;
      end
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 65534; i++) drive(0, 0, 0, 0, 1, 32'h0);
    n_tests++;
    if (udf_cnt !== 16'hFFFE) begin
      $display("FAIL sat_fffe: got %h expected fffe", udf_cnt);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 32'h0);
      n_tests++;
      if (udf_cnt !== 16'hFFFF) begin
        $display("FAIL sat_pop_%0d: got %h expected ffff", i, udf_cnt);
        n_fail++;
      end
    end
    drive(0, 0, 0, 1, 0, 32'h900);
    drive(1, 0, 0, 1, 0, 32'h904);
    n_tests++;
    if (dut_vec() !== {32'h0, 1'b1, 1'b0, 16'h0, 16'h0}) begin
      $display("FAIL sat_reset: got %h expected %h", dut_vec(),
               {32'h0, 1'b1, 1'b0, 16'h0, 16'h0});
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
    addr_in = 32'h0;
    m_ovf = 16'h0;
    m_udf = 16'h0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_stall_flush();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
